sync_fifo_ext: RTL and testbench

Parametrised synchronous FIFO: the successor to `sync_fifo`, generalised in data width and depth. It adds programmable almost-full and almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between instruction/data producers and consumers in the same clock domain, for example as the instruction buffer with `DWIDTH` set to `INST_WIDTH`.

---
 rtl/sync_fifo_ext_if.sv | 28 ++
 rtl/sync_fifo_ext.sv | 102 ++++++++++
 tb/tb_sync_fifo_ext.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ext_if.sv
// Handshake/data bundle between a sync_fifo_ext and its producer/consumer.
// master = the side driving requests, slave = the FIFO itself.
interface sync_fifo_ext_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4
);
    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, overflow/underflow pulses and optional
// first-word-fall-through read mode. All flags decode the registered count.
module sync_fifo_ext #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = (2**AWIDTH) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic           clk,
    input logic           reset,
    sync_fifo_ext_if.slave fif
);
    localparam int              DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);
    localparam bit              FWFT_B  = (FWFT != 0);

    // Storage carries no reset; the pointers and count define what is valid.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    // Standard mode: registered read data. FWFT mode: last word shown,
    // presented while the FIFO is empty.
    logic [DWIDTH-1:0] dout_q, dout_d;

    logic full_c, empty_c, wr_acc, rd_acc;

    // Acceptance, pointer/count next state, error pulses and read data.
    always_comb begin
        full_c  = (count_q == DEPTH_C);
        empty_c = (count_q == '0);
        wr_acc  = fif.wr_en && !full_c;
        rd_acc  = fif.rd_en && !empty_c;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;

        if (wr_acc) wptr_d = wptr_q + AWIDTH'(1);
        if (rd_acc) rptr_d = rptr_q + AWIDTH'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ovf_d = fif.wr_en && full_c;
        unf_d = fif.rd_en && empty_c;

        if (FWFT_B) begin
            // Remember what is on dout so it can be held once the FIFO drains.
            if (!empty_c) dout_d = mem_q[rptr_q];
        end else begin
            if (rd_acc) dout_d = mem_q[rptr_q];
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= fif.din;
    end

    // Outputs: flags from registered count; FWFT shows head word directly.
    always_comb begin
        fif.count        = count_q;
        fif.full         = full_c;
        fif.empty        = empty_c;
        fif.almost_full  = (count_q >= AF_C);
        fif.almost_empty = (count_q <= AE_C);
        fif.overflow     = ovf_q;
        fif.underflow    = unf_q;
        fif.dout         = (FWFT_B && !empty_c) ? mem_q[rptr_q] : dout_q;
    end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: one standard-mode and one FWFT instance
// share the same stimulus; a queue model predicts each cycle's response.
module tb_sync_fifo_ext;
    localparam int DW = 16, AW = 3, DEPTH = 8, AF = 6, AE = 2;

    logic clk = 1'b0;
    logic reset;
    logic wr, rd;
    logic [DW-1:0] din;

    always #5 clk = ~clk;

    sync_fifo_ext_if #(.DWIDTH(DW), .AWIDTH(AW)) if0 ();
    sync_fifo_ext_if #(.DWIDTH(DW), .AWIDTH(AW)) if1 ();

    assign if0.wr_en = wr;
    assign if0.rd_en = rd;
    assign if0.din   = din;
    assign if1.wr_en = wr;
    assign if1.rd_en = rd;
    assign if1.din   = din;

    sync_fifo_ext #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .fif(if0)
    );
    sync_fifo_ext #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .fif(if1)
    );

    typedef struct {
        int          cnt;
        bit          ovf;
        bit          unf;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] m_d0, m_d1;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_state(input exp_t e);
        chk("std.count",        32'(if0.count),        32'(e.cnt));
        chk("std.full",         32'(if0.full),         32'(e.cnt == DEPTH));
        chk("std.empty",        32'(if0.empty),        32'(e.cnt == 0));
        chk("std.almost_full",  32'(if0.almost_full),  32'(e.cnt >= AF));
        chk("std.almost_empty", 32'(if0.almost_empty), 32'(e.cnt <= AE));
        chk("std.overflow",     32'(if0.overflow),     32'(e.ovf));
        chk("std.underflow",    32'(if0.underflow),    32'(e.unf));
        chk("std.dout",         32'(if0.dout),         32'(e.d0));
        chk("fwft.count",       32'(if1.count),        32'(e.cnt));
        chk("fwft.empty",       32'(if1.empty),        32'(e.cnt == 0));
        chk("fwft.full",        32'(if1.full),         32'(e.cnt == DEPTH));
        chk("fwft.overflow",    32'(if1.overflow),     32'(e.ovf));
        chk("fwft.underflow",   32'(if1.underflow),    32'(e.unf));
        chk("fwft.dout",        32'(if1.dout),         32'(e.d1));
    endtask

    // Drive one cycle of stimulus and predict the state after the next edge.
    task automatic cyc(input bit w, input bit r, input logic [15:0] d);
        exp_t e;
        int   n;
        @(negedge clk);
        wr = w; rd = r; din = d;
        n = mq.size();
        e.ovf = w && (n == DEPTH);
        e.unf = r && (n == 0);
        if (r && n != 0) m_d0 = mq.pop_front();
        if (w && n != DEPTH) mq.push_back(d);
        if (mq.size() != 0) m_d1 = mq[0];
        e.cnt = mq.size();
        e.d0  = m_d0;
        e.d1  = m_d1;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT state just after each edge against the prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_state(e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rst_e;
        int   pw;
        rst_e.cnt = 0; rst_e.ovf = 0; rst_e.unf = 0; rst_e.d0 = '0; rst_e.d1 = '0;
        m_d0 = '0; m_d1 = '0;
        reset = 1'b1; wr = 0; rd = 0; din = '0;
        #12;
        check_state(rst_e);
        @(negedge clk);
        reset = 1'b0;

        // Fill, then one rejected write.
        for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i));
        cyc(1, 0, 16'h0009);
        cyc(0, 0, 16'h0000);

        // Drain, then one rejected read.
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'h0000);
        cyc(0, 1, 16'h0000);
        cyc(0, 0, 16'h0000);

        // Simultaneous access at count=4 across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1, 0, 16'(16'h0100 + i));
        for (int i = 0; i < 20; i++) cyc(1, 1, 16'(16'h0200 + i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0000);

        // Both at full: read wins, write overflows.
        for (int i = 0; i < 8; i++) cyc(1, 0, 16'(16'h0300 + i));
        cyc(1, 1, 16'hDEAD);
        for (int i = 0; i < 7; i++) cyc(0, 1, 16'h0000);
        // Both at empty: write wins, read underflows.
        cyc(1, 1, 16'h0BEE);
        cyc(0, 1, 16'h0000);

        // FWFT fall-through and pop to empty.
        cyc(1, 0, 16'hA5A5);
        cyc(0, 0, 16'h0000);
        cyc(0, 1, 16'h0000);
        cyc(0, 0, 16'h0000);

        // Asynchronous reset at count=5, between edges.
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'(16'h0400 + i));
        @(posedge clk);
        #3;
        reset = 1'b1; wr = 0; rd = 0;
        #1;
        mq.delete();
        m_d0 = '0; m_d1 = '0;
        check_state(rst_e);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 16'h1234);
        cyc(0, 1, 16'h0000);
        cyc(0, 0, 16'h0000);

        // Random traffic with a write bias that sweeps through full and empty.
        for (int i = 0; i < 2000; i++) begin
            case ((i / 250) % 4)
                0:       pw = 80;
                1:       pw = 50;
                2:       pw = 20;
                default: pw = 50;
            endcase
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 16'($urandom));
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
